pwm_capture: RTL and testbench



---
 rtl/pwm_cap_pkg.sv | 28 ++
 rtl/pwm_cap_sync.sv | 82 ++++++++
 rtl/pwm_capture.sv | 194 +++++++++++++++++++
 tb/tb_pwm_capture.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_cap_pkg.sv
// Shared definitions for the PWM input capture block.
//   - APB register offsets (byte address bits [7:0])
//   - CTRL / STATUS bit positions
//   - Capture FSM state encoding
package pwm_cap_pkg;

  localparam logic [7:0] REG_CTRL   = 8'h40;
  localparam logic [7:0] REG_STATUS = 8'h44;
  localparam logic [7:0] REG_PERIOD = 8'h48;
  localparam logic [7:0] REG_HIGH   = 8'h4C;
  localparam logic [7:0] REG_CNT    = 8'h50;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_INV    = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_VALID = 0;
  localparam int STAT_OVF   = 1;
  localparam int STAT_BUSY  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } cap_state_e;

endpackage

// File: rtl/pwm_cap_sync.sv
// Input conditioning for pwm_capture.
//   Synchronizes the asynchronous pwm_in, optionally glitch-filters it
//   (macro PWM_CAP_FILTER_EN), and emits one-cycle rise/fall pulses of the
//   active level. Edges are detected on the raw level and swapped when inv is
//   set, so toggling inv never fabricates an edge.
// Ports:
//   apb_pclk  in  clock
//   apb_prst  in  synchronous active-high reset
//   pwm_in    in  asynchronous PWM input
//   inv       in  1 = measure the low-active pulse
//   rise      out registered pulse: active level went high
//   fall      out registered pulse: active level went low
module pwm_cap_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic apb_pclk,
  input  logic apb_prst,
  input  logic pwm_in,
  input  logic inv,
  output logic rise,
  output logic fall
);

  if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_bad_param
    $error("pwm_cap_sync: SYNC_STAGES must be >= 2 and FILT_LEN >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl_s;
  logic                   lvl_f;
  logic                   prev_q;

  // synchronizer stage
  always_ff @(posedge apb_pclk) begin
    if (apb_prst) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
  end

  assign lvl_s = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAP_FILTER_EN
  localparam int RUN_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [RUN_W-1:0] run_q;
  logic             filt_q;

  // glitch filter stage: run_q counts consecutive samples that disagree
  // with the accepted level; the level flips on the FILT_LEN-th one.
  always_ff @(posedge apb_pclk) begin
    if (apb_prst) begin
      run_q  <= '0;
      filt_q <= 1'b0;
    end else if (lvl_s == filt_q) begin
      run_q <= '0;
    end else if (run_q == RUN_W'(FILT_LEN - 1)) begin
      filt_q <= lvl_s;
      run_q  <= '0;
    end else begin
      run_q <= run_q + RUN_W'(1);
    end
  end

  assign lvl_f = filt_q;
`else
  assign lvl_f = lvl_s;
`endif

  // edge stage
  always_ff @(posedge apb_pclk) begin
    if (apb_prst) begin
      prev_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      prev_q <= lvl_f;
      rise   <= inv ? (~lvl_f & prev_q) : (lvl_f & ~prev_q);
      fall   <= inv ? (lvl_f & ~prev_q) : (~lvl_f & prev_q);
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// APB-slave PWM input capture.
//   Measures period and active time of pwm_in in apb_pclk cycles. Results in
//   PERIOD/HIGH, sticky valid/ovf in STATUS, level interrupt on cap_irq.
//   Optional glitch filter on the input: define PWM_CAP_FILTER_EN.
// Ports:
//   apb_pclk     in   clock, sole domain
//   apb_prst     in   synchronous active-high reset
//   apb_psel     in   APB select
//   apb_paddr    in   [31:0] address, [7:0] decoded
//   apb_penable  in   APB access phase
//   apb_pwrite   in   1 = write
//   apb_pwdata   in   [31:0] write data
//   apb_prdata   out  [31:0] combinational read data, 0 when not reading
//   pwm_in       in   asynchronous PWM input
//   cap_irq      out  irq_en & (valid | ovf)
module pwm_capture
  import pwm_cap_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic        apb_pclk,
  input  logic        apb_prst,
  input  logic        apb_psel,
  input  logic [31:0] apb_paddr,
  input  logic        apb_penable,
  input  logic        apb_pwrite,
  input  logic [31:0] apb_pwdata,
  output logic [31:0] apb_prdata,
  input  logic        pwm_in,
  output logic        cap_irq
);

  if (CNT_W < 2 || CNT_W > 32) begin : g_bad_param
    $error("pwm_capture: CNT_W must be in 2..32");
  end

  logic       we;
  logic       re;
  logic [7:0] addr;
  logic       unused_bits;

  assign we          = apb_psel & apb_penable & apb_pwrite;
  assign re          = apb_psel & apb_penable & ~apb_pwrite;
  assign addr        = apb_paddr[7:0];
  assign unused_bits = ^{apb_paddr[31:8], apb_pwdata[31:3]};

  logic             en_q, inv_q, irq_en_q;
  logic             valid_q, ovf_q;
  logic [CNT_W-1:0] period_q, high_q, cnt_q, hi_lat_q;
  cap_state_e       state_q;

  logic             rise, fall;
  cap_state_e       state_d;
  logic [CNT_W-1:0] cnt_d;
  logic             cap_ld, lat_ld, ovf_set;
  logic             ctrl_wr, stat_wr, busy;

  function automatic logic is_saturated(input logic [CNT_W-1:0] c);
    return &c;
  endfunction

  pwm_cap_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_sync (
    .apb_pclk (apb_pclk),
    .apb_prst (apb_prst),
    .pwm_in   (pwm_in),
    .inv      (inv_q),
    .rise     (rise),
    .fall     (fall)
  );

  // next-state and counter decision
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_ld  = 1'b0;
    lat_ld  = 1'b0;
    ovf_set = 1'b0;
    if (!en_q) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_ARM;
          cnt_d   = '0;
        end
        ST_ARM: begin
          cnt_d = '0;
          if (rise) begin
            state_d = ST_HIGH;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_HIGH: begin
          if (is_saturated(cnt_q)) begin
            ovf_set = 1'b1;
            state_d = ST_ARM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (fall) begin
              lat_ld  = 1'b1;
              state_d = ST_LOW;
            end
          end
        end
        ST_LOW: begin
          if (is_saturated(cnt_q)) begin
            ovf_set = 1'b1;
            state_d = ST_ARM;
            cnt_d   = '0;
          end else if (rise) begin
            cap_ld  = 1'b1;
            state_d = ST_HIGH;
            cnt_d   = CNT_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign ctrl_wr = we && (addr == REG_CTRL);
  assign stat_wr = we && (addr == REG_STATUS);

  // register stage: FSM, counter, captures, CSRs
  always_ff @(posedge apb_pclk) begin
    if (apb_prst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_lat_q <= '0;
      period_q <= '0;
      high_q   <= '0;
      en_q     <= 1'b0;
      inv_q    <= 1'b0;
      irq_en_q <= 1'b0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (lat_ld) hi_lat_q <= cnt_q;
      // PERIOD and HIGH move together so a reader never sees a torn pair
      if (cap_ld) begin
        period_q <= cnt_q;
        high_q   <= hi_lat_q;
      end
      if (ctrl_wr) begin
        en_q     <= apb_pwdata[CTRL_EN];
        inv_q    <= apb_pwdata[CTRL_INV];
        irq_en_q <= apb_pwdata[CTRL_IRQ_EN];
      end
      // hardware set beats a simultaneous W1C
      valid_q <= cap_ld  | (valid_q & ~(stat_wr & apb_pwdata[STAT_VALID]));
      ovf_q   <= ovf_set | (ovf_q   & ~(stat_wr & apb_pwdata[STAT_OVF]));
    end
  end

  assign busy    = (state_q == ST_HIGH) || (state_q == ST_LOW);
  assign cap_irq = irq_en_q & (valid_q | ovf_q);

  always_comb begin
    apb_prdata = '0;
    if (re) begin
      unique case (addr)
        REG_CTRL: begin
          apb_prdata[CTRL_EN]     = en_q;
          apb_prdata[CTRL_INV]    = inv_q;
          apb_prdata[CTRL_IRQ_EN] = irq_en_q;
        end
        REG_STATUS: begin
          apb_prdata[STAT_VALID] = valid_q;
          apb_prdata[STAT_OVF]   = ovf_q;
          apb_prdata[STAT_BUSY]  = busy;
        end
        REG_PERIOD: apb_prdata = 32'(period_q);
        REG_HIGH:   apb_prdata = 32'(high_q);
        REG_CNT:    apb_prdata = 32'(cnt_q);
        default:    apb_prdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
module tb_pwm_capture;

  localparam logic [31:0] A_CTRL   = 32'h40;
  localparam logic [31:0] A_STATUS = 32'h44;
  localparam logic [31:0] A_PERIOD = 32'h48;
  localparam logic [31:0] A_HIGH   = 32'h4C;
  localparam logic [31:0] A_CNT    = 32'h50;
  localparam logic [31:0] A_NONE   = 32'h54;

`ifdef PWM_CAP_FILTER_EN
  localparam int LAT = 2 + 4 + 1;
`else
  localparam int LAT = 2 + 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic        pwm_in;
  logic        tgt8;
  logic        psel32, psel8;
  logic [31:0] prdata32, prdata8;
  logic        irq32, irq8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign psel32 = psel & ~tgt8;
  assign psel8  = psel & tgt8;

  pwm_capture dut (
    .apb_pclk    (clk),
    .apb_prst    (rst),
    .apb_psel    (psel32),
    .apb_paddr   (paddr),
    .apb_penable (penable),
    .apb_pwrite  (pwrite),
    .apb_pwdata  (pwdata),
    .apb_prdata  (prdata32),
    .pwm_in      (pwm_in),
    .cap_irq     (irq32)
  );

  pwm_capture #(.CNT_W(8)) dut8 (
    .apb_pclk    (clk),
    .apb_prst    (rst),
    .apb_psel    (psel8),
    .apb_paddr   (paddr),
    .apb_penable (penable),
    .apb_pwrite  (pwrite),
    .apb_pwdata  (pwdata),
    .apb_prdata  (prdata8),
    .pwm_in      (pwm_in),
    .cap_irq     (irq8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = a;
    #3;
    d = tgt8 ? prdata8 : prdata32;
    check(tag, d, exp);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // hold pwm_in at v for n sampling edges; returns just after a posedge
  task automatic level(input logic v, input int n);
    pwm_in = v;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pwm_in = 1'b0; tgt8 = 1'b0;

    // 1: reset with a toggling input
    repeat (6) begin @(posedge clk); #1; pwm_in = ~pwm_in; end
    rst = 1'b0;
    check("rst_irq", {31'b0, irq32}, 32'h0);
    rd_check("rst_ctrl",   A_CTRL,   32'h0);
    rd_check("rst_status", A_STATUS, 32'h0);
    rd_check("rst_period", A_PERIOD, 32'h0);
    rd_check("rst_high",   A_HIGH,   32'h0);
    rd_check("rst_cnt",    A_CNT,    32'h0);
    tgt8 = 1'b1;
    rd_check("rst_status8", A_STATUS, 32'h0);
    tgt8 = 1'b0;
    repeat (8) level(~pwm_in, 3);
    rd_check("dis_cnt", A_CNT, 32'h0);
    rd_check("unmapped", A_NONE, 32'h0);
    apb_wr(A_CTRL, 32'hFFFF_FFF8);
    rd_check("ctrl_rsvd", A_CTRL, 32'h0);

    // 2: normal capture, period 100 high 30, irq enabled
    level(1'b0, 4);
    apb_wr(A_CTRL, 32'h5);
    rd_check("ctrl_rb", A_CTRL, 32'h5);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = A_CTRL;
    #3 check("prdata_no_re", prdata32, 32'h0);
    psel = 1'b0;
    level(1'b1, 30); level(1'b0, 70); level(1'b1, 30); level(1'b0, 70);
    level(1'b1, 12);
    rd_check("n_period", A_PERIOD, 32'd100);
    rd_check("n_high",   A_HIGH,   32'd30);
    rd_check("n_status", A_STATUS, 32'h5);
    check("n_irq", {31'b0, irq32}, 32'h1);
    apb_wr(A_STATUS, 32'h1);
    check("n_irq_clr", {31'b0, irq32}, 32'h0);
    rd_check("n_status_clr", A_STATUS, 32'h4);
    level(1'b0, 10);

    // 3: inverted measurement
    apb_wr(A_CTRL, 32'h0);
    apb_wr(A_STATUS, 32'h3);
    apb_wr(A_CTRL, 32'h3);
    level(1'b1, 30); level(1'b0, 70); level(1'b1, 30); level(1'b0, 70);
    level(1'b1, 30); level(1'b0, 10);
    rd_check("i_period", A_PERIOD, 32'd100);
    rd_check("i_high",   A_HIGH,   32'd70);
    rd_check("i_status", A_STATUS, 32'h5);
    check("i_irq_off", {31'b0, irq32}, 32'h0);

    // 5: disable in LOW, then set-vs-W1C race
    apb_wr(A_CTRL, 32'h0);
    apb_wr(A_STATUS, 32'h3);
    apb_wr(A_CTRL, 32'h1);
    level(1'b1, 40); level(1'b0, 60); level(1'b1, 40); level(1'b0, 20);
    rd_check("d_status_low", A_STATUS, 32'h5);
    apb_wr(A_CTRL, 32'h0);
    rd_check("d_status_idle", A_STATUS, 32'h1);
    rd_check("d_cnt",    A_CNT,    32'h0);
    rd_check("d_period", A_PERIOD, 32'd100);
    rd_check("d_high",   A_HIGH,   32'd40);
    apb_wr(A_STATUS, 32'h1);
    rd_check("d_status_w1c", A_STATUS, 32'h0);
    apb_wr(A_CTRL, 32'h1);
    level(1'b1, 30); level(1'b0, 30);
    pwm_in = 1'b1;
    repeat (LAT - 1) begin @(posedge clk); #1; end
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = A_STATUS; pwdata = 32'h1;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    rd_check("race_status", A_STATUS, 32'h5);
    rd_check("race_period", A_PERIOD, 32'd60);
    rd_check("race_high",   A_HIGH,   32'd30);

    // 6: glitch rejection (filter build) and clean 50/20 waveform
    apb_wr(A_CTRL, 32'h0);
    apb_wr(A_STATUS, 32'h3);
    level(1'b0, 10);
    apb_wr(A_CTRL, 32'h1);
`ifdef PWM_CAP_FILTER_EN
    level(1'b1, 2); level(1'b0, 20);
    rd_check("f_glitch_status", A_STATUS, 32'h0);
`endif
    level(1'b1, 20); level(1'b0, 30); level(1'b1, 20); level(1'b0, 30);
    level(1'b1, 20); level(1'b0, 15);
    rd_check("c_period", A_PERIOD, 32'd50);
    rd_check("c_high",   A_HIGH,   32'd20);
    rd_check("c_status", A_STATUS, 32'h5);

    // 4: saturation on the 8-bit instance
    apb_wr(A_CTRL, 32'h0);
    tgt8 = 1'b1;
    apb_wr(A_CTRL, 32'h1);
    level(1'b1, 8); level(1'b0, 12); level(1'b1, 300);
    rd_check("o_status", A_STATUS, 32'h3);
    rd_check("o_period", A_PERIOD, 32'd20);
    rd_check("o_high",   A_HIGH,   32'd8);
    rd_check("o_cnt",    A_CNT,    32'h0);
    check("o_irq_off", {31'b0, irq8}, 32'h0);
    apb_wr(A_CTRL, 32'h5);
    check("o_irq_on", {31'b0, irq8}, 32'h1);
    apb_wr(A_STATUS, 32'h2);
    rd_check("o_status_w1c", A_STATUS, 32'h1);
    tgt8 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
